// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage.
// Imported by the MEM stage, its bus sub-unit and its interface.
package mem_stage_pkg;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int ISA_EXP_W   = 3;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;
   typedef logic [WORD_DATA_W-1:0] word_data_t;
   typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
   typedef logic [MEM_OP_W-1:0]    mem_op_t;
   typedef logic [CTRL_OP_W-1:0]   ctrl_op_t;
   typedef logic [ISA_EXP_W-1:0]   isa_exp_t;

   localparam mem_op_t MEM_OP_NOP = 2'd0;
   localparam mem_op_t MEM_OP_LDW = 2'd1;
   localparam mem_op_t MEM_OP_STW = 2'd2;

   localparam isa_exp_t ISA_EXP_NO_EXP     = 3'd0;
   localparam isa_exp_t ISA_EXP_MISS_ALIGN = 3'd4;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_REQ    = 2'd1,
      BUS_ACCESS = 2'd2,
      BUS_STALL  = 2'd3
   } bus_state_t;

   typedef struct packed {
      word_addr_t pc;
      logic       en;
      logic       br_flag;
      ctrl_op_t   ctrl_op;
      reg_addr_t  dst_addr;
      logic       gpr_we_;
      isa_exp_t   exp_code;
      word_data_t out;
   } mem_wb_t;

   localparam mem_wb_t MEM_WB_RST = '{
      pc:       '0,
      en:       1'b0,
      br_flag:  1'b0,
      ctrl_op:  '0,
      dst_addr: '0,
      gpr_we_:  DISABLE_,
      exp_code: ISA_EXP_NO_EXP,
      out:      '0
   };

   function automatic logic is_mem_op(input mem_op_t op);
      return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Memory-side signals of the MEM stage: scratch-pad port and
// shared arbitrated bus port.
interface mem_stage_if;
   import mem_stage_pkg::*;

   word_data_t spm_rd_data;
   word_addr_t spm_addr;
   logic       spm_as_;
   logic       spm_rw;
   word_data_t spm_wr_data;

   word_data_t bus_rd_data;
   logic       bus_rdy_;
   logic       bus_grnt_;
   logic       bus_req_;
   word_addr_t bus_addr;
   logic       bus_as_;
   logic       bus_rw;
   word_data_t bus_wr_data;

   modport master (
      input  spm_rd_data,
      output spm_addr, spm_as_, spm_rw, spm_wr_data,
      input  bus_rd_data, bus_rdy_, bus_grnt_,
      output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
   );

   modport slave (
      output spm_rd_data,
      input  spm_addr, spm_as_, spm_rw, spm_wr_data,
      output bus_rd_data, bus_rdy_, bus_grnt_,
      input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
   );

endinterface

// File: rtl/mem_bus_if.sv
// SPM / bus access unit: region decode, bus request FSM and
// read buffer that holds bus data while the pipeline is stalled.
module mem_bus_if
   import mem_stage_pkg::*;
#(
   parameter logic [2:0] SPM_SEL = 3'b011
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       stall,
   input  logic       flush,
   input  mem_op_t    mem_op,
   input  logic       access,
   input  word_addr_t addr,
   input  word_data_t wr_data,
   output word_data_t rd_data,
   output logic       busy,
   mem_stage_if.master mif
);

   bus_state_t state;
   bus_state_t state_nxt;
   word_data_t rd_buf;
   logic       rd_buf_we;
   logic       op_rw;
   logic       spm_hit;
   logic       bus_hit;

   assign op_rw   = (mem_op == MEM_OP_LDW) ? READ : WRITE;
   assign spm_hit = access & (addr[29:27] == SPM_SEL);
   assign bus_hit = access & (addr[29:27] != SPM_SEL);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state  <= BUS_IDLE;
         rd_buf <= '0;
      end else begin
         state <= state_nxt;
         if (rd_buf_we) rd_buf <= mif.bus_rd_data;
      end
   end

   always_comb begin
      state_nxt       = state;
      rd_data         = '0;
      busy            = 1'b0;
      rd_buf_we       = 1'b0;
      mif.spm_addr    = addr;
      mif.spm_as_     = DISABLE_;
      mif.spm_rw      = op_rw;
      mif.spm_wr_data = wr_data;
      mif.bus_req_    = DISABLE_;
      mif.bus_addr    = '0;
      mif.bus_as_     = DISABLE_;
      mif.bus_rw      = READ;
      mif.bus_wr_data = '0;
      unique case (state)
         BUS_IDLE: begin
            if (spm_hit) begin
               mif.spm_as_ = ENABLE_;
               rd_data     = mif.spm_rd_data;
            end else if (bus_hit && !flush) begin
               mif.bus_req_ = ENABLE_;
               busy         = 1'b1;
               state_nxt    = BUS_REQ;
            end
         end
         BUS_REQ: begin
            mif.bus_req_ = ENABLE_;
            busy         = 1'b1;
            if (mif.bus_grnt_ == ENABLE_) begin
               mif.bus_as_     = ENABLE_;
               mif.bus_addr    = addr;
               mif.bus_rw      = op_rw;
               mif.bus_wr_data = wr_data;
               state_nxt       = BUS_ACCESS;
            end
         end
         BUS_ACCESS: begin
            mif.bus_req_ = ENABLE_;
            busy         = 1'b1;
            if (mif.bus_rdy_ == ENABLE_) begin
               mif.bus_req_ = DISABLE_;
               busy         = 1'b0;
               rd_buf_we    = 1'b1;
               rd_data      = mif.bus_rd_data;
               state_nxt    = stall ? BUS_STALL : BUS_IDLE;
            end
         end
         BUS_STALL: begin
            // pipeline still held: replay buffered bus data
            rd_data = rd_buf;
            if (!stall) state_nxt = BUS_IDLE;
         end
         default: state_nxt = BUS_IDLE;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: alignment check, SPM/bus access and the
// MEM/WB pipeline register with forwarding output.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter logic [2:0] SPM_SEL = 3'b011
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       stall,
   input  logic       flush,
   output logic       busy,
   input  word_addr_t ex_pc,
   input  logic       ex_en,
   input  logic       ex_br_flag,
   input  mem_op_t    ex_mem_op,
   input  word_data_t ex_mem_wr_data,
   input  ctrl_op_t   ex_ctrl_op,
   input  reg_addr_t  ex_dst_addr,
   input  logic       ex_gpr_we_,
   input  isa_exp_t   ex_exp_code,
   input  word_data_t ex_out,
   mem_stage_if.master mif,
   output word_addr_t mem_pc,
   output logic       mem_en,
   output logic       mem_br_flag,
   output ctrl_op_t   mem_ctrl_op,
   output reg_addr_t  mem_dst_addr,
   output logic       mem_gpr_we_,
   output isa_exp_t   mem_exp_code,
   output word_data_t mem_out,
   output word_data_t fwd_data
);

   logic       mem_req;
   logic       access;
   logic       miss_align;
   word_data_t rd_data;
   word_data_t result;
   mem_wb_t    wb;

   assign mem_req    = ex_en & is_mem_op(ex_mem_op);
   assign access     = mem_req & (ex_out[1:0] == 2'b00);
   assign miss_align = mem_req & (ex_out[1:0] != 2'b00);

   mem_bus_if #(
      .SPM_SEL (SPM_SEL)
   ) u_bus (
      .clk     (clk),
      .reset_  (reset_),
      .stall   (stall),
      .flush   (flush),
      .mem_op  (ex_mem_op),
      .access  (access),
      .addr    (ex_out[31:2]),
      .wr_data (ex_mem_wr_data),
      .rd_data (rd_data),
      .busy    (busy),
      .mif     (mif)
   );

   assign result   = (access && ex_mem_op == MEM_OP_LDW) ? rd_data : ex_out;
   assign fwd_data = result;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wb <= MEM_WB_RST;
      end else if (!stall) begin
         if (flush) begin
            wb <= MEM_WB_RST;
         end else if (miss_align) begin
            wb <= '{
               pc:       ex_pc,
               en:       ex_en,
               br_flag:  ex_br_flag,
               ctrl_op:  ex_ctrl_op,
               dst_addr: ex_dst_addr,
               gpr_we_:  DISABLE_,
               exp_code: ISA_EXP_MISS_ALIGN,
               out:      '0
            };
         end else begin
            wb <= '{
               pc:       ex_pc,
               en:       ex_en,
               br_flag:  ex_br_flag,
               ctrl_op:  ex_ctrl_op,
               dst_addr: ex_dst_addr,
               gpr_we_:  ex_gpr_we_,
               exp_code: ex_exp_code,
               out:      result
            };
         end
      end
   end

   assign mem_pc       = wb.pc;
   assign mem_en       = wb.en;
   assign mem_br_flag  = wb.br_flag;
   assign mem_ctrl_op  = wb.ctrl_op;
   assign mem_dst_addr = wb.dst_addr;
   assign mem_gpr_we_  = wb.gpr_we_;
   assign mem_exp_code = wb.exp_code;
   assign mem_out      = wb.out;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-timeline model, SPM/bus slaves,
// per-cycle compare process and directed vectors.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset_ = 1'b1;
   logic        ext_stall = 1'b0;
   logic        flush = 1'b0;
   logic        stall;
   logic        busy;
   logic [29:0] ex_pc = '0;
   logic        ex_en = 1'b0;
   logic        ex_br_flag = 1'b0;
   logic [1:0]  ex_mem_op = '0;
   logic [31:0] ex_mem_wr_data = '0;
   logic [1:0]  ex_ctrl_op = '0;
   logic [4:0]  ex_dst_addr = '0;
   logic        ex_gpr_we_ = 1'b1;
   logic [2:0]  ex_exp_code = '0;
   logic [31:0] ex_out = '0;
   logic [29:0] mem_pc;
   logic        mem_en;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic        mem_gpr_we_;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;
   logic [31:0] fwd_data;

   mem_stage_if mif();

   // pipeline control: busy always forces a stall
   assign stall = busy | ext_stall;

   mem_stage dut (
      .clk(clk), .reset_(reset_), .stall(stall), .flush(flush),
      .busy(busy), .ex_pc(ex_pc), .ex_en(ex_en),
      .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
      .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
      .ex_exp_code(ex_exp_code), .ex_out(ex_out), .mif(mif),
      .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
      .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
      .mem_out(mem_out), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   logic        exp_busy = 1'b0, exp_req_ = 1'b1, exp_as_ = 1'b1;
   logic        exp_spm_as_ = 1'b1, exp_rw = 1'b1, exp_fwd_vld = 1'b0;
   logic [29:0] exp_addr = '0;
   logic [31:0] exp_wd = '0, exp_fwd = '0, cur_result = '0;

   logic [31:0] spm_slv [logic [29:0]];
   logic [31:0] spm_mdl [logic [29:0]];
   logic [31:0] bus_slv [logic [29:0]];
   logic [31:0] bus_mdl [logic [29:0]];

   int req_total = 0, as_total = 0, spm_total = 0;
   logic [29:0] last_spm_addr = '0, last_bus_addr = '0;
   logic        last_bus_rw = 1'b1;
   logic [29:0] pc_ctr = 30'h100;

   logic        s_stall = 1'b1, s_flush = 1'b0, s_en = 1'b0;
   logic        s_br = 1'b0, s_we = 1'b1;
   logic [1:0]  s_op = '0, s_ctrl = '0;
   logic [4:0]  s_dst = '0;
   logic [2:0]  s_exp = '0;
   logic [29:0] s_pc = '0;
   logic [31:0] s_out = '0, s_result = '0;

   logic        m_en = 1'b0, m_br = 1'b0, m_we = 1'b1;
   logic [1:0]  m_ctrl = '0;
   logic [4:0]  m_dst = '0;
   logic [2:0]  m_exp = '0;
   logic [29:0] m_pc = '0;
   logic [31:0] m_out = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // MEM/WB model: what the register must hold after each edge
   initial forever begin
      @(posedge clk or negedge reset_);
      if (!reset_ || (!s_stall && s_flush)) begin
         m_pc = '0; m_en = 1'b0; m_br = 1'b0; m_ctrl = '0;
         m_dst = '0; m_we = 1'b1; m_exp = 3'd0; m_out = '0;
      end else if (!s_stall) begin
         m_pc = s_pc; m_en = s_en; m_br = s_br;
         m_ctrl = s_ctrl; m_dst = s_dst;
         if (s_en && (s_op == 2'd1 || s_op == 2'd2) && s_out[1:0] != 2'd0) begin
            m_we = 1'b1; m_exp = 3'd4; m_out = '0;
         end else begin
            m_we = s_we; m_exp = s_exp; m_out = s_result;
         end
      end
   end

   // compare, memory slaves and input sampling
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("bus_req_", 32'(mif.bus_req_), 32'(exp_req_));
         chk("bus_as_", 32'(mif.bus_as_), 32'(exp_as_));
         chk("spm_as_", 32'(mif.spm_as_), 32'(exp_spm_as_));
         if (!exp_as_) begin
            chk("bus_addr", 32'(mif.bus_addr), 32'(exp_addr));
            chk("bus_rw", 32'(mif.bus_rw), 32'(exp_rw));
            chk("bus_wr_data", mif.bus_wr_data, exp_wd);
         end else begin
            chk("bus_addr_idle", 32'(mif.bus_addr), 32'h0);
            chk("bus_rw_idle", 32'(mif.bus_rw), 32'h1);
            chk("bus_wd_idle", mif.bus_wr_data, 32'h0);
         end
         if (!exp_spm_as_) begin
            chk("spm_addr", 32'(mif.spm_addr), 32'(exp_addr));
            chk("spm_rw", 32'(mif.spm_rw), 32'(exp_rw));
            if (!exp_rw) chk("spm_wr_data", mif.spm_wr_data, exp_wd);
         end
         if (exp_fwd_vld) chk("fwd_data", fwd_data, exp_fwd);
         chk("mem_pc", 32'(mem_pc), 32'(m_pc));
         chk("mem_en", 32'(mem_en), 32'(m_en));
         chk("mem_br_flag", 32'(mem_br_flag), 32'(m_br));
         chk("mem_ctrl_op", 32'(mem_ctrl_op), 32'(m_ctrl));
         chk("mem_dst_addr", 32'(mem_dst_addr), 32'(m_dst));
         chk("mem_gpr_we_", 32'(mem_gpr_we_), 32'(m_we));
         chk("mem_exp_code", 32'(mem_exp_code), 32'(m_exp));
         chk("mem_out", mem_out, m_out);
      end
      if (!mif.bus_req_) req_total++;
      if (!mif.bus_as_) begin
         as_total++;
         last_bus_addr = mif.bus_addr;
         last_bus_rw = mif.bus_rw;
         if (!mif.bus_rw) bus_slv[mif.bus_addr] = mif.bus_wr_data;
      end
      if (!mif.spm_as_) begin
         spm_total++;
         last_spm_addr = mif.spm_addr;
         if (!mif.spm_rw) spm_slv[mif.spm_addr] = mif.spm_wr_data;
      end
      s_stall = stall; s_flush = flush; s_en = ex_en; s_op = ex_mem_op;
      s_out = ex_out; s_pc = ex_pc; s_br = ex_br_flag; s_ctrl = ex_ctrl_op;
      s_dst = ex_dst_addr; s_we = ex_gpr_we_; s_exp = ex_exp_code;
      s_result = cur_result;
   end

   function automatic logic [31:0] rd_mem(input bit spm, input bit mdl,
                                          input logic [29:0] w);
      if (spm && mdl) return spm_mdl.exists(w) ? spm_mdl[w] : 32'h0;
      if (spm) return spm_slv.exists(w) ? spm_slv[w] : 32'h0;
      if (mdl) return bus_mdl.exists(w) ? bus_mdl[w] : 32'h0;
      return bus_slv.exists(w) ? bus_slv[w] : 32'h0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_exp();
      exp_busy = 1'b0; exp_req_ = 1'b1; exp_as_ = 1'b1;
      exp_spm_as_ = 1'b1; exp_fwd_vld = 1'b0;
   endtask

   task automatic set_ex(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
      pc_ctr = pc_ctr + 30'd3;
      ex_pc = pc_ctr; ex_en = 1'b1; ex_br_flag = pc_ctr[0];
      ex_ctrl_op = pc_ctr[2:1]; ex_dst_addr = pc_ctr[4:0];
      ex_gpr_we_ = (op == 2'd1) ? 1'b0 : 1'b1;
      ex_exp_code = (op == 2'd0) ? 3'd2 : 3'd0;
      ex_mem_op = op; ex_out = a; ex_mem_wr_data = wd;
      exp_addr = a[31:2]; exp_rw = (op == 2'd1); exp_wd = wd;
      mif.spm_rd_data = 32'h5A5A_0000;
      idle_exp();
   endtask

   // NOP or misaligned op: one cycle, result is ex_out
   task automatic plain_op(input logic [1:0] op, input logic [31:0] a);
      set_ex(op, a, 32'h0);
      cur_result = a; exp_fwd = a; exp_fwd_vld = 1'b1;
      step();
   endtask

   task automatic spm_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
      set_ex(op, a, wd);
      if (op == 2'd1) mif.spm_rd_data = rd_mem(1'b1, 1'b0, a[31:2]);
      cur_result = (op == 2'd1) ? rd_mem(1'b1, 1'b1, a[31:2]) : a;
      exp_spm_as_ = 1'b0; exp_fwd = cur_result; exp_fwd_vld = 1'b1;
      step();
      if (op == 2'd2) spm_mdl[a[31:2]] = wd;
   endtask

   // g: REQ cycles before grant, r: ACCESS cycles before rdy,
   // s: extra stall cycles after rdy, fl: flush held through ACCESS
   task automatic bus_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input int g, input int r,
                         input int s, input bit fl);
      set_ex(op, a, wd);
      cur_result = (op == 2'd1) ? rd_mem(1'b0, 1'b1, a[31:2]) : a;
      exp_busy = 1'b1; exp_req_ = 1'b0;
      step();
      for (int i = 0; i <= g; i++) begin
         mif.bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
         exp_as_ = (i == g) ? 1'b0 : 1'b1;
         step();
      end
      mif.bus_grnt_ = 1'b1; exp_as_ = 1'b1;
      for (int i = 0; i <= r; i++) begin
         flush = fl;
         if (i == r) begin
            mif.bus_rdy_ = 1'b0;
            mif.bus_rd_data = rd_mem(1'b0, 1'b0, a[31:2]);
            exp_busy = 1'b0; exp_req_ = 1'b1; ext_stall = (s > 0);
            exp_fwd = cur_result; exp_fwd_vld = 1'b1;
         end else begin
            mif.bus_rdy_ = 1'b1; mif.bus_rd_data = 32'hBAD0_BAD0;
         end
         step();
      end
      mif.bus_rdy_ = 1'b1; mif.bus_rd_data = 32'hBAD0_BAD0;
      for (int i = 0; i < s; i++) begin
         ext_stall = (i < s - 1);
         step();
      end
      ext_stall = 1'b0; flush = 1'b0;
      if (op == 2'd2) bus_mdl[a[31:2]] = wd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int r0, a0, s0;

   initial begin
      mif.bus_grnt_ = 1'b1; mif.bus_rdy_ = 1'b1;
      mif.bus_rd_data = 32'hBAD0_BAD0; mif.spm_rd_data = '0;
      spm_slv[30'h1800_0004] = 32'hDEAD_BEEF;
      spm_mdl[30'h1800_0004] = 32'hDEAD_BEEF;
      bus_slv[30'h80] = 32'hCAFE_F00D;
      bus_mdl[30'h80] = 32'hCAFE_F00D;
      #1 reset_ = 1'b0;
      step(); step();
      chk_on = 1'b1;
      step();
      chk("reset_gpr_we_", 32'(mem_gpr_we_), 32'h1);
      chk("reset_mem_en", 32'(mem_en), 32'h0);
      reset_ = 1'b1;

      plain_op(2'd0, 32'h1111_2222);
      chk("nop_out", mem_out, 32'h1111_2222);

      s0 = spm_total;
      spm_op(2'd1, 32'h6000_0010, 32'h0);
      chk("spm_ldw_addr", 32'(last_spm_addr), 32'h1800_0004);
      chk("spm_ldw_out", mem_out, 32'hDEAD_BEEF);
      chk("spm_ldw_we_", 32'(mem_gpr_we_), 32'h0);
      chk("spm_ldw_strobes", 32'(spm_total - s0), 32'd1);

      spm_op(2'd2, 32'h6000_0020, 32'hA5A5_5A5A);
      spm_op(2'd1, 32'h6000_0020, 32'h0);
      chk("spm_rmw_out", mem_out, 32'hA5A5_5A5A);

      r0 = req_total; a0 = as_total;
      bus_op(2'd2, 32'h0000_0100, 32'h1234_5678, 2, 0, 0, 1'b0);
      chk("bus_stw_req_cycles", 32'(req_total - r0), 32'd4);
      chk("bus_stw_strobes", 32'(as_total - a0), 32'd1);
      chk("bus_stw_addr", 32'(last_bus_addr), 32'h40);
      chk("bus_stw_rw", 32'(last_bus_rw), 32'h0);

      r0 = req_total;
      bus_op(2'd1, 32'h0000_0100, 32'h0, 0, 1, 2, 1'b0);
      chk("bus_ldw_stall_req", 32'(req_total - r0), 32'd3);
      chk("bus_ldw_stall_out", mem_out, 32'h1234_5678);

      r0 = req_total; s0 = spm_total;
      plain_op(2'd1, 32'h6000_0012);
      chk("mis_exp", 32'(mem_exp_code), 32'h4);
      chk("mis_we_", 32'(mem_gpr_we_), 32'h1);
      chk("mis_out", mem_out, 32'h0);
      chk("mis_pc", 32'(mem_pc), 32'(pc_ctr));
      plain_op(2'd2, 32'h0000_0103);
      chk("mis_no_req", 32'(req_total - r0), 32'd0);
      chk("mis_no_spm", 32'(spm_total - s0), 32'd0);

      r0 = req_total;
      set_ex(2'd1, 32'h0000_0200, 32'h0);
      flush = 1'b1; cur_result = 32'h0000_0200;
      step();
      flush = 1'b0;
      chk("flush_idle_no_req", 32'(req_total - r0), 32'd0);
      chk("flush_idle_en", 32'(mem_en), 32'h0);

      a0 = as_total;
      bus_op(2'd1, 32'h0000_0200, 32'h0, 1, 2, 0, 1'b1);
      chk("flush_acc_strobes", 32'(as_total - a0), 32'd1);
      chk("flush_acc_en", 32'(mem_en), 32'h0);
      chk("flush_acc_we_", 32'(mem_gpr_we_), 32'h1);

      bus_op(2'd1, 32'h0000_0200, 32'h0, 0, 0, 0, 1'b0);
      chk("bus_ldw_min_out", mem_out, 32'hCAFE_F00D);

      set_ex(2'd1, 32'h0000_0200, 32'h0);
      cur_result = 32'hCAFE_F00D;
      exp_busy = 1'b1; exp_req_ = 1'b0;
      step();
      @(negedge clk);
      #2;
      reset_ = 1'b0; ex_en = 1'b0; idle_exp();
      #1;
      chk("rst_req_", 32'(mif.bus_req_), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_en", 32'(mem_en), 32'h0);
      chk("rst_we_", 32'(mem_gpr_we_), 32'h1);
      chk("rst_out", mem_out, 32'h0);
      step(); step();
      reset_ = 1'b1;

      spm_op(2'd1, 32'h6000_0010, 32'h0);
      chk("post_rst_spm", mem_out, 32'hDEAD_BEEF);
      plain_op(2'd0, 32'h0BAD_F00D);
      step();
      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
